// File: rtl/v_seq_ctrl_if.sv
// Handshake bundle between the decoder/execution units and the vector sequencer.
// The sequencer takes the slave view; the environment (decoder + units) takes the master view.
interface v_seq_ctrl_if #(
  parameter int LANES = 4,
  parameter int VL_W  = 6
);
  logic              instr_valid;
  logic              instr_ready;
  logic              is_vconfig;
  logic [31:0]       cfg_avl;
  logic [3:0]        v_alu_op;
  logic              is_mul;
  logic [2:0]        v_red_op;
  logic [2:0]        v_sldu_op;
  logic [3:0]        v_lsu_op;
  logic [VL_W-1:0]   vl;
  logic [2:0]        unit_sel;
  logic              eg_valid;
  logic              eg_ready;
  logic [VL_W-1:0]   eg_idx;
  logic [LANES-1:0]  eg_mask;
  logic              red_last;
  logic              lsu_done;
  logic              done;
  logic              illegal;
  logic              busy;

  modport slave (
    input  instr_valid, is_vconfig, cfg_avl, v_alu_op, is_mul, v_red_op, v_sldu_op, v_lsu_op,
    input  eg_ready, lsu_done,
    output instr_ready, vl, unit_sel, eg_valid, eg_idx, eg_mask, red_last, done, illegal, busy
  );

  modport master (
    output instr_valid, is_vconfig, cfg_avl, v_alu_op, is_mul, v_red_op, v_sldu_op, v_lsu_op,
    output eg_ready, lsu_done,
    input  instr_ready, vl, unit_sel, eg_valid, eg_idx, eg_mask, red_last, done, illegal, busy
  );
endinterface

// File: rtl/v_seq_ctrl.sv
// Vector instruction sequencer: holds vl, splits a vector op into LANES-wide element
// groups for the selected execution unit, waits for drain, then pulses done.
module v_seq_ctrl #(
  parameter int LANES   = 4,
  parameter int VLMAX   = 32,
  parameter int VL_W    = 6,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         nrst,
  v_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, LSU_WAIT, DRAIN, DONE} state_t;

  localparam logic [2:0] U_NONE = 3'd0;
  localparam logic [2:0] U_ALU  = 3'd1;
  localparam logic [2:0] U_MUL  = 3'd2;
  localparam logic [2:0] U_RED  = 3'd3;
  localparam logic [2:0] U_SLDU = 3'd4;
  localparam logic [2:0] U_LSU  = 3'd5;
  localparam int         DR_W   = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  state_t            state_r;
  logic [VL_W-1:0]   vl_r;
  logic [VL_W-1:0]   eg_idx_r;
  logic [LANES-1:0]  eg_mask_r;
  logic [2:0]        unit_sel_r;
  logic [DR_W-1:0]   drain_cnt_r;
  logic              eg_valid_r;
  logic              red_last_r;
  logic              done_r;
  logic              illegal_r;
  logic              instr_ready_r;
  logic              busy_r;

  logic [2:0]        dec_unit_s;
  logic [VL_W-1:0]   cfg_vl_s;
  logic [VL_W-1:0]   nxt_idx_s;
  logic              accept_s;
  logic              hs_s;
  logic              last_s;

  function automatic logic [LANES-1:0] grp_mask(input logic [VL_W-1:0] idx,
                                                input logic [VL_W-1:0] len);
    logic [LANES-1:0] m;
    m = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      m[i] = ((32'(idx) * 32'(LANES)) + 32'(i)) < 32'(len);
    end
    return m;
  endfunction

  function automatic logic grp_last(input logic [VL_W-1:0] idx, input logic [VL_W-1:0] len);
    return ((32'(idx) + 32'd1) * 32'(LANES)) >= 32'(len);
  endfunction

  // Unit decode with fixed priority, AVL saturation and handshake qualifiers.
  always_comb begin
    dec_unit_s = U_NONE;
    cfg_vl_s   = {VL_W{1'b0}};
    if (bus.v_lsu_op != 4'd0) begin
      dec_unit_s = U_LSU;
    end else if (bus.v_red_op != 3'd0) begin
      dec_unit_s = U_RED;
    end else if (bus.v_sldu_op != 3'd0) begin
      dec_unit_s = U_SLDU;
    end else if (bus.is_mul) begin
      dec_unit_s = U_MUL;
    end else if (bus.v_alu_op != 4'd0) begin
      dec_unit_s = U_ALU;
    end else begin
      dec_unit_s = U_NONE;
    end
    if (bus.cfg_avl > 32'(VLMAX)) begin
      cfg_vl_s = VL_W'(VLMAX);
    end else begin
      cfg_vl_s = bus.cfg_avl[VL_W-1:0];
    end
    accept_s  = bus.instr_valid && instr_ready_r;
    hs_s      = eg_valid_r && bus.eg_ready;
    nxt_idx_s = eg_idx_r + {{(VL_W-1){1'b0}}, 1'b1};
    last_s    = grp_last(eg_idx_r, vl_r);
  end

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= IDLE;
      vl_r          <= {VL_W{1'b0}};
      eg_idx_r      <= {VL_W{1'b0}};
      eg_mask_r     <= {LANES{1'b0}};
      unit_sel_r    <= U_NONE;
      drain_cnt_r   <= {DR_W{1'b0}};
      eg_valid_r    <= 1'b0;
      red_last_r    <= 1'b0;
      done_r        <= 1'b0;
      illegal_r     <= 1'b0;
      instr_ready_r <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            instr_ready_r <= 1'b0;
            busy_r        <= 1'b1;
            if (bus.is_vconfig) begin
              vl_r    <= cfg_vl_s;
              state_r <= DONE;
              done_r  <= 1'b1;
            end else if (dec_unit_s == U_NONE) begin
              state_r   <= DONE;
              done_r    <= 1'b1;
              illegal_r <= 1'b1;
            end else if (vl_r == {VL_W{1'b0}}) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= ISSUE;
              unit_sel_r <= dec_unit_s;
              eg_valid_r <= 1'b1;
              eg_idx_r   <= {VL_W{1'b0}};
              eg_mask_r  <= grp_mask({VL_W{1'b0}}, vl_r);
              red_last_r <= (dec_unit_s == U_RED) && grp_last({VL_W{1'b0}}, vl_r);
            end
          end
        end
        ISSUE: begin
          if (hs_s) begin
            if (unit_sel_r == U_LSU) begin
              // The LSU may report completion in the very cycle it takes the request.
              eg_valid_r <= 1'b0;
              if (bus.lsu_done) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= LSU_WAIT;
              end
            end else if (last_s) begin
              eg_valid_r <= 1'b0;
              red_last_r <= 1'b0;
              if ((unit_sel_r == U_MUL) && (MUL_LAT > 0)) begin
                state_r     <= DRAIN;
                drain_cnt_r <= DR_W'(MUL_LAT);
              end else begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end
            end else begin
              eg_idx_r   <= nxt_idx_s;
              eg_mask_r  <= grp_mask(nxt_idx_s, vl_r);
              red_last_r <= (unit_sel_r == U_RED) && grp_last(nxt_idx_s, vl_r);
            end
          end
        end
        LSU_WAIT: begin
          if (bus.lsu_done) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_r <= DR_W'(1)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - DR_W'(1);
          end
        end
        DONE: begin
          state_r       <= IDLE;
          unit_sel_r    <= U_NONE;
          instr_ready_r <= 1'b1;
          busy_r        <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          unit_sel_r    <= U_NONE;
          eg_valid_r    <= 1'b0;
          red_last_r    <= 1'b0;
          instr_ready_r <= 1'b1;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_r;
  assign bus.vl          = vl_r;
  assign bus.unit_sel    = unit_sel_r;
  assign bus.eg_valid    = eg_valid_r;
  assign bus.eg_idx      = eg_idx_r;
  assign bus.eg_mask     = eg_mask_r;
  assign bus.red_last    = red_last_r;
  assign bus.done        = done_r;
  assign bus.illegal     = illegal_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_v_seq_ctrl.sv
// Directed bench for v_seq_ctrl: a scoreboard of expected element groups and done
// pulses is filled when an instruction is sent and drained as the DUT hands them out.
module tb_v_seq_ctrl;
  localparam int LANES   = 4;
  localparam int VLMAX   = 32;
  localparam int VL_W    = 6;
  localparam int MUL_LAT = 2;

  logic clk;
  logic nrst;

  v_seq_ctrl_if #(.LANES(LANES), .VL_W(VL_W)) bus ();

  v_seq_ctrl #(.LANES(LANES), .VLMAX(VLMAX), .VL_W(VL_W), .MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       unit;
    logic [VL_W-1:0]  idx;
    logic [LANES-1:0] mask;
    logic             red_last;
  } eg_t;

  eg_t  exp_q[$];
  logic exp_done_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   acc_cyc = 0;
  int   model_vl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle at the negedge, after inputs for the next posedge are driven.
  task automatic mon();
    eg_t e;
    cyc_n++;
    if (bus.eg_valid && bus.eg_ready) begin
      if (exp_q.size() == 0) begin
        chk("eg_unexpected", {31'd0, bus.eg_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("eg_unit", {29'd0, bus.unit_sel}, {29'd0, e.unit});
        chk("eg_idx", {26'd0, bus.eg_idx}, {26'd0, e.idx});
        chk("eg_mask", {28'd0, bus.eg_mask}, {28'd0, e.mask});
        chk("eg_red_last", {31'd0, bus.red_last}, {31'd0, e.red_last});
      end
    end
    if (bus.done) begin
      done_cnt++;
      last_done_cyc = cyc_n;
      if (exp_done_q.size() == 0) begin
        chk("done_unexpected", {31'd0, bus.done}, 32'd0);
      end else begin
        chk("done_illegal", {31'd0, bus.illegal}, {31'd0, exp_done_q.pop_front()});
      end
    end
  endtask

  task automatic clr_instr();
    bus.instr_valid = 1'b0;
    bus.is_vconfig  = 1'b0;
    bus.cfg_avl     = 32'd0;
    bus.v_alu_op    = 4'd0;
    bus.is_mul      = 1'b0;
    bus.v_red_op    = 3'd0;
    bus.v_sldu_op   = 3'd0;
    bus.v_lsu_op    = 4'd0;
  endtask

  task automatic tick(input logic rdy, input logic ld);
    @(negedge clk);
    clr_instr();
    bus.eg_ready = rdy;
    bus.lsu_done = ld;
    mon();
  endtask

  function automatic logic [LANES-1:0] mdl_mask(input int g);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (g * LANES + i) < model_vl;
    return m;
  endfunction

  task automatic send(input logic vcfg, input logic [31:0] avl, input logic [3:0] alu,
                      input logic mul, input logic [2:0] red, input logic [2:0] sldu,
                      input logic [3:0] lsu);
    logic [2:0] u;
    eg_t e;
    @(negedge clk);
    bus.is_vconfig  = vcfg;
    bus.cfg_avl     = avl;
    bus.v_alu_op    = alu;
    bus.is_mul      = mul;
    bus.v_red_op    = red;
    bus.v_sldu_op   = sldu;
    bus.v_lsu_op    = lsu;
    bus.instr_valid = 1'b1;
    bus.eg_ready    = 1'b1;
    bus.lsu_done    = 1'b0;
    mon();
    chk("instr_ready_accept", {31'd0, bus.instr_ready}, 32'd1);
    acc_cyc = cyc_n;
    if (lsu != 4'd0) u = 3'd5;
    else if (red != 3'd0) u = 3'd3;
    else if (sldu != 3'd0) u = 3'd4;
    else if (mul) u = 3'd2;
    else if (alu != 4'd0) u = 3'd1;
    else u = 3'd0;
    if (vcfg) begin
      model_vl = (avl > 32'(VLMAX)) ? VLMAX : int'(avl);
      exp_done_q.push_back(1'b0);
    end else if (u == 3'd0) begin
      exp_done_q.push_back(1'b1);
    end else if (model_vl == 0) begin
      exp_done_q.push_back(1'b0);
    end else if (u == 3'd5) begin
      e = '{unit: u, idx: '0, mask: mdl_mask(0), red_last: 1'b0};
      exp_q.push_back(e);
      exp_done_q.push_back(1'b0);
    end else begin
      for (int g = 0; g * LANES < model_vl; g++) begin
        e = '{unit: u, idx: VL_W'(g), mask: mdl_mask(g),
              red_last: (u == 3'd3) && ((g + 1) * LANES >= model_vl)};
        exp_q.push_back(e);
      end
      exp_done_q.push_back(1'b0);
    end
  endtask

  task automatic wait_done(input int budget, input logic rdy, input logic ld,
                           input int lat, input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while ((done_cnt == start) && (n < budget)) begin
      tick(rdy, ld);
      n++;
    end
    chk({tag, "_done"}, 32'(done_cnt - start), 32'd1);
    chk({tag, "_lat"}, 32'(last_done_cyc - acc_cyc), 32'(lat));
    chk({tag, "_eg_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    clr_instr();
    bus.eg_ready = 1'b0;
    bus.lsu_done = 1'b0;

    // reset state
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("rst_eg_valid", {31'd0, bus.eg_valid}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("rst_red_last", {31'd0, bus.red_last}, 32'd0);
    chk("rst_vl", {26'd0, bus.vl}, 32'd0);
    chk("rst_unit_sel", {29'd0, bus.unit_sel}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    nrst = 1'b1;
    tick(1'b1, 1'b0);
    chk("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);

    // 1: vconfig 10
    send(1'b1, 32'd10, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg10");
    chk("vcfg10_vl", {26'd0, bus.vl}, 32'd10);

    // 2: ALU over vl=10 -> masks 1111,1111,0011
    send(1'b0, 32'd0, 4'd1, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(16, 1'b1, 1'b0, 4, "alu10");

    // 3: reduction vl=8 with a stall on group 1
    send(1'b1, 32'd8, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg8");
    send(1'b0, 32'd0, 4'd0, 1'b0, 3'd1, 3'd0, 4'd0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0);
      chk("red_stall_valid", {31'd0, bus.eg_valid}, 32'd1);
      chk("red_stall_idx", {26'd0, bus.eg_idx}, 32'd1);
      chk("red_stall_mask", {28'd0, bus.eg_mask}, 32'hF);
      chk("red_stall_unit", {29'd0, bus.unit_sel}, 32'd3);
      chk("red_stall_last", {31'd0, bus.red_last}, 32'd1);
    end
    wait_done(16, 1'b1, 1'b0, 5, "red8");
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);

    // 4: vmul vl=8, pending instruction held off until IDLE
    send(1'b0, 32'd0, 4'd0, 1'b1, 3'd0, 3'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.is_vconfig  = 1'b1;
      bus.cfg_avl     = 32'd3;
      bus.eg_ready    = 1'b1;
      bus.lsu_done    = 1'b0;
      mon();
      chk("mul_instr_ready_busy", {31'd0, bus.instr_ready}, 32'd0);
      chk("mul_busy", {31'd0, bus.busy}, 32'd1);
    end
    wait_done(8, 1'b1, 1'b0, 5, "mul8");
    tick(1'b1, 1'b0);
    chk("mul_vl_kept", {26'd0, bus.vl}, 32'd8);
    chk("mul_unit_cleared", {29'd0, bus.unit_sel}, 32'd0);

    // 5: LSU vl=5 (ALU field also set, LSU wins), lsu_done 7 cycles later
    send(1'b1, 32'd5, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg5");
    send(1'b0, 32'd0, 4'd3, 1'b0, 3'd0, 3'd0, 4'd1);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    wait_done(8, 1'b1, 1'b0, 8, "lsu5");
    send(1'b0, 32'd0, 4'd0, 1'b0, 3'd0, 3'd0, 4'd2);
    wait_done(8, 1'b1, 1'b1, 2, "lsu_same");
    send(1'b1, 32'hFFFF_FFFF, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg_max");
    chk("vcfg_max_vl", {26'd0, bus.vl}, 32'd32);
    send(1'b1, 32'h0001_0005, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg_hi");
    chk("vcfg_hi_vl", {26'd0, bus.vl}, 32'd32);
    send(1'b0, 32'd0, 4'd0, 1'b1, 3'd0, 3'd2, 4'd0);
    wait_done(24, 1'b1, 1'b0, 9, "sldu32");

    // 6: illegal, vl=0, reset mid-issue
    send(1'b0, 32'd0, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "illegal");
    chk("illegal_vl_kept", {26'd0, bus.vl}, 32'd32);
    send(1'b1, 32'd0, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg0");
    chk("vcfg0_vl", {26'd0, bus.vl}, 32'd0);
    send(1'b0, 32'd0, 4'd1, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "alu_vl0");
    send(1'b1, 32'd10, 4'd0, 1'b0, 3'd0, 3'd0, 4'd0);
    wait_done(8, 1'b1, 1'b0, 1, "vcfg10b");
    send(1'b0, 32'd0, 4'd1, 1'b0, 3'd0, 3'd0, 4'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("mid_eg_valid", {31'd0, bus.eg_valid}, 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid_rst_eg_valid", {31'd0, bus.eg_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_vl", {26'd0, bus.vl}, 32'd0);
    exp_q.delete();
    exp_done_q.delete();
    model_vl = 0;
    tick(1'b1, 1'b0);
    nrst = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    chk("mid_rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_rst_unit_sel", {29'd0, bus.unit_sel}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
